// File: rtl/riscv_decode_stage.sv
// riscv_decode_stage
//   Registered RV32 decode stage between fetch and execute. Decodes the RV32I
//   integer ALU ops, LUI, AUIPC, LW, SW and (optionally) the M-extension
//   multiplies into an execute bundle. The stage holds two entries: the output
//   register plus one skid register. The skid holds already-decoded bundles.
//
// Ports
//   clk, rst_n          rising-edge clock, async active-low reset
//   flush               drop everything held and the instruction offered this cycle
//   in_valid/in_ready   fetch handshake (in_ready is registered: !skid_full)
//   in_inst, in_pc      instruction word and its address
//   out_valid/out_ready execute handshake
//   out_*               decoded bundle (enums encoded as below, X encodings are 0)
//   illegal_cnt         saturating count of illegal instructions handed to execute
//
// Encodings
//   exec_fun: X=0 ADD=1 SUB=2 AND=3 OR=4 XOR=5 SLL=6 SRL=7 SRA=8 SLT=9 SLTU=10
//             MUL=11 MULH=12 MULHSU=13 MULHU=14
//   op1_sel : X=0 RS1=1 PC=2   (X means operand 1 is zero)
//   op2_sel : X=0 RS2=1 IMM=2
//   wb_sel  : X=0 ALU=1 MEM=2
module riscv_decode_stage #(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [3:0]       out_exec_fun,
  output logic [1:0]       out_op1_sel,
  output logic [1:0]       out_op2_sel,
  output logic [1:0]       out_wb_sel,
  output logic             out_mem_we,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_invalid,
  output logic [CNT_W-1:0] illegal_cnt
);

  if (XLEN != 32) begin : g_xlen_chk
    $error("riscv_decode_stage: XLEN must be 32");
  end

  localparam logic [3:0] ALU_X    = 4'd0,  ALU_ADD  = 4'd1,  ALU_SUB    = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3,  ALU_OR   = 4'd4,  ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6,  ALU_SRL  = 4'd7,  ALU_SRA    = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9,  ALU_SLTU = 4'd10, ALU_MUL    = 4'd11;
  localparam logic [3:0] ALU_MULH = 4'd12, ALU_MULHSU = 4'd13, ALU_MULHU = 4'd14;

  localparam logic [1:0] OP1_X = 2'd0, OP1_RS1 = 2'd1, OP1_PC  = 2'd2;
  localparam logic [1:0] OP2_X = 2'd0, OP2_RS2 = 2'd1, OP2_IMM = 2'd2;
  localparam logic [1:0] WB_X  = 2'd0, WB_ALU  = 2'd1, WB_MEM  = 2'd2;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [3:0]      fun;
    logic [1:0]      op1;
    logic [1:0]      op2;
    logic [1:0]      wb;
    logic            mem_we;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            invalid;
  } bundle_t;

  // ---------------------------------------------------------------- decode
  bundle_t    dec;
  logic       legal, wr_rd, we;
  logic [3:0] fun;
  logic [1:0] op1, op2, wb;
  logic [31:0] imm;
  logic [6:0] opc, f7;
  logic [2:0] f3;

  assign opc = in_inst[6:0];
  assign f3  = in_inst[14:12];
  assign f7  = in_inst[31:25];

  always_comb begin
    legal = 1'b0;
    wr_rd = 1'b1;
    we    = 1'b0;
    fun   = ALU_X;
    op1   = OP1_X;
    op2   = OP2_X;
    wb    = WB_X;
    imm   = '0;
    case (opc)
      OPC_OP: begin
        legal = 1'b1;
        op1   = OP1_RS1;
        op2   = OP2_RS2;
        wb    = WB_ALU;
        case (f7)
          7'b0000000: begin
            case (f3)
              3'd0: fun = ALU_ADD;
              3'd1: fun = ALU_SLL;
              3'd2: fun = ALU_SLT;
              3'd3: fun = ALU_SLTU;
              3'd4: fun = ALU_XOR;
              3'd5: fun = ALU_SRL;
              3'd6: fun = ALU_OR;
              default: fun = ALU_AND;
            endcase
          end
          7'b0100000: begin
            if (f3 == 3'd0)      fun = ALU_SUB;
            else if (f3 == 3'd5) fun = ALU_SRA;
            else                 legal = 1'b0;
          end
          7'b0000001: begin
            // Only the multiplies; divides are not supported by execute.
            if (ENABLE_M != 0 && !f3[2]) begin
              case (f3[1:0])
                2'd0: fun = ALU_MUL;
                2'd1: fun = ALU_MULH;
                2'd2: fun = ALU_MULHSU;
                default: fun = ALU_MULHU;
              endcase
            end else begin
              legal = 1'b0;
            end
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_OPIMM: begin
        legal = 1'b1;
        op1   = OP1_RS1;
        op2   = OP2_IMM;
        wb    = WB_ALU;
        imm   = {{20{in_inst[31]}}, in_inst[31:20]};
        case (f3)
          3'd0: fun = ALU_ADD;
          3'd2: fun = ALU_SLT;
          3'd3: fun = ALU_SLTU;
          3'd4: fun = ALU_XOR;
          3'd6: fun = ALU_OR;
          3'd7: fun = ALU_AND;
          3'd1: begin
            fun   = ALU_SLL;
            imm   = {27'b0, in_inst[24:20]};
            legal = (f7 == 7'b0000000);
          end
          default: begin
            imm = {27'b0, in_inst[24:20]};
            if (f7 == 7'b0000000)      fun = ALU_SRL;
            else if (f7 == 7'b0100000) fun = ALU_SRA;
            else                       legal = 1'b0;
          end
        endcase
      end
      OPC_LUI, OPC_AUIPC: begin
        legal = 1'b1;
        op1   = (opc == OPC_AUIPC) ? OP1_PC : OP1_X;
        op2   = OP2_IMM;
        wb    = WB_ALU;
        fun   = ALU_ADD;
        imm   = {in_inst[31:12], 12'b0};
      end
      OPC_LOAD: begin
        legal = (f3 == 3'b010);
        op1   = OP1_RS1;
        op2   = OP2_IMM;
        wb    = WB_MEM;
        fun   = ALU_ADD;
        imm   = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      OPC_STORE: begin
        legal = (f3 == 3'b010);
        wr_rd = 1'b0;
        we    = 1'b1;
        op1   = OP1_RS1;
        op2   = OP2_IMM;
        fun   = ALU_ADD;
        imm   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      default: legal = 1'b0;
    endcase

    // Illegal words collapse to the all-X bundle; register indices stay raw.
    dec         = '0;
    dec.pc      = in_pc;
    dec.rs1     = in_inst[19:15];
    dec.rs2     = in_inst[24:20];
    dec.invalid = !legal;
    if (legal) begin
      dec.fun    = fun;
      dec.op1    = op1;
      dec.op2    = op2;
      dec.wb     = wb;
      dec.mem_we = we;
      dec.rd     = wr_rd ? in_inst[11:7] : 5'd0;
      dec.imm    = imm;
    end
  end

  // ------------------------------------------------------- output + skid
  bundle_t         out_q, out_d, skid_q, skid_d;
  logic            out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            in_fire, out_fire;

  // in_ready comes straight off the skid flop, never from out_ready.
  assign in_ready = !skid_valid_q;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    cnt_d        = cnt_q;

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      // Output slot frees this edge; the skid is older than any new input.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end

    // A bundle taken by execute counts even on a flush cycle: it was delivered.
    if (out_fire && out_q.invalid && cnt_q != {CNT_W{1'b1}})
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_pc       = out_q.pc;
  assign out_exec_fun = out_q.fun;
  assign out_op1_sel  = out_q.op1;
  assign out_op2_sel  = out_q.op2;
  assign out_wb_sel   = out_q.wb;
  assign out_mem_we   = out_q.mem_we;
  assign out_rs1      = out_q.rs1;
  assign out_rs2      = out_q.rs2;
  assign out_rd       = out_q.rd;
  assign out_imm      = out_q.imm;
  assign out_invalid  = out_q.invalid;
  assign illegal_cnt  = cnt_q;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Directed bench for riscv_decode_stage. Three instances share the same
// stimulus: base (ENABLE_M=0, CNT_W=16), M-enabled, and a 2-bit counter one.
module tb_riscv_decode_stage;

  localparam logic [3:0] F_X = 0, F_ADD = 1, F_SUB = 2, F_SRA = 8, F_MUL = 11;
  localparam logic [1:0] S_X = 0, S_RS = 1, S_OTHER = 2;  // op1 PC / op2 IMM / wb MEM = 2

  localparam logic [31:0] I_ADD  = 32'h002081B3, I_SUB = 32'h402081B3;
  localparam logic [31:0] I_ADDI = 32'h00500093, I_LUI = 32'h123452B7;
  localparam logic [31:0] I_SW   = 32'h0020A423, I_LW  = 32'hFFC0A103;
  localparam logic [31:0] I_SRAI = 32'h4030D093, I_MUL = 32'h022081B3;
  localparam logic [31:0] I_BADSLLI = 32'h40309093;

  logic clk, rst_n, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;

  logic        rdy_a, ov_a, we_a, inv_a;
  logic [31:0] pc_a, imm_a;
  logic [3:0]  fn_a;
  logic [1:0]  o1_a, o2_a, wb_a;
  logic [4:0]  rs1_a, rs2_a, rd_a;
  logic [15:0] cnt_a;

  logic        rdy_m, ov_m, we_m, inv_m;
  logic [31:0] pc_m, imm_m;
  logic [3:0]  fn_m;
  logic [1:0]  o1_m, o2_m, wb_m;
  logic [4:0]  rs1_m, rs2_m, rd_m;
  logic [15:0] cnt_m;

  logic        rdy_c, ov_c, we_c, inv_c;
  logic [31:0] pc_c, imm_c;
  logic [3:0]  fn_c;
  logic [1:0]  o1_c, o2_c, wb_c;
  logic [4:0]  rs1_c, rs2_c, rd_c;
  logic [1:0]  cnt_c;

  int checks = 0;
  int failures = 0;

  riscv_decode_stage #(.XLEN(32), .ENABLE_M(0), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(ov_a), .out_ready(out_ready),
    .out_pc(pc_a), .out_exec_fun(fn_a), .out_op1_sel(o1_a), .out_op2_sel(o2_a),
    .out_wb_sel(wb_a), .out_mem_we(we_a), .out_rs1(rs1_a), .out_rs2(rs2_a),
    .out_rd(rd_a), .out_imm(imm_a), .out_invalid(inv_a), .illegal_cnt(cnt_a));

  riscv_decode_stage #(.XLEN(32), .ENABLE_M(1), .CNT_W(16)) dut_m (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy_m),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(ov_m), .out_ready(out_ready),
    .out_pc(pc_m), .out_exec_fun(fn_m), .out_op1_sel(o1_m), .out_op2_sel(o2_m),
    .out_wb_sel(wb_m), .out_mem_we(we_m), .out_rs1(rs1_m), .out_rs2(rs2_m),
    .out_rd(rd_m), .out_imm(imm_m), .out_invalid(inv_m), .illegal_cnt(cnt_m));

  riscv_decode_stage #(.XLEN(32), .ENABLE_M(0), .CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy_c),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(ov_c), .out_ready(out_ready),
    .out_pc(pc_c), .out_exec_fun(fn_c), .out_op1_sel(o1_c), .out_op2_sel(o2_c),
    .out_wb_sel(wb_c), .out_mem_we(we_c), .out_rs1(rs1_c), .out_rs2(rs2_c),
    .out_rd(rd_c), .out_imm(imm_c), .out_invalid(inv_c), .illegal_cnt(cnt_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic drive(input logic v, input logic [31:0] inst, input logic rdy);
    in_valid  = v;
    in_inst   = inst;
    out_ready = rdy;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = 32'h100;
    #12;
    chk("rst_out_valid", {31'b0, ov_a}, 0);
    chk("rst_in_ready", {31'b0, rdy_a}, 1);
    chk("rst_cnt", {16'b0, cnt_a}, 0);
    chk("rst_bundle", {fn_a, o1_a, o2_a, wb_a, we_a, rd_a, inv_a}, 0);
    chk("rst_imm", imm_a, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // One bundle per cycle with out_ready held high.
    drive(1, I_ADD, 1);
    chk("add_valid", {31'b0, ov_a}, 1);
    chk("add_ctl", {fn_a, o1_a, o2_a, wb_a}, {F_ADD, S_RS, S_RS, S_RS});
    chk("add_regs", {rs1_a, rs2_a, rd_a}, {5'd1, 5'd2, 5'd3});
    chk("add_pc", pc_a, 32'h100);
    chk("add_inv", {31'b0, inv_a}, 0);
    in_pc = 32'h104;
    drive(1, I_SUB, 1);
    chk("sub_fun", {28'b0, fn_a}, F_SUB);
    drive(1, I_ADDI, 1);
    chk("addi_ctl", {fn_a, o1_a, o2_a, wb_a}, {F_ADD, S_RS, S_OTHER, S_RS});
    chk("addi_imm", imm_a, 5);
    chk("addi_rd", {27'b0, rd_a}, 1);
    drive(1, I_LUI, 1);
    chk("lui_ctl", {fn_a, o1_a, o2_a}, {F_ADD, S_X, S_OTHER});
    chk("lui_imm", imm_a, 32'h12345000);
    chk("lui_rd", {27'b0, rd_a}, 5);
    drive(1, I_SW, 1);
    chk("sw_we", {31'b0, we_a}, 1);
    chk("sw_imm", imm_a, 8);
    chk("sw_rd_wb", {rd_a, wb_a}, {5'd0, S_X});
    drive(1, I_LW, 1);
    chk("lw_imm", imm_a, 32'hFFFFFFFC);
    chk("lw_wb_we", {wb_a, we_a}, {S_OTHER, 1'b0});
    chk("lw_rd", {27'b0, rd_a}, 2);
    drive(1, I_SRAI, 1);
    chk("srai", {fn_a, o2_a, imm_a[7:0]}, {F_SRA, S_OTHER, 8'd3});

    // M extension and illegal counting.
    drive(1, I_MUL, 1);
    chk("mul_base_inv", {inv_a, fn_a, rd_a}, {1'b1, F_X, 5'd0});
    chk("mul_m", {inv_m, fn_m, rd_m}, {1'b0, F_MUL, 5'd3});
    drive(1, 32'h0, 1);
    chk("zero_inv", {inv_a, inv_m, o1_a, wb_a, imm_a[3:0]}, {1'b1, 1'b1, S_X, S_X, 4'd0});
    chk("cnt_after_mul", {cnt_a, cnt_m}, {16'd1, 16'd0});
    drive(1, I_BADSLLI, 1);
    chk("badslli_inv", {31'b0, inv_m}, 1);
    chk("cnt_s10", {cnt_a, cnt_m}, {16'd2, 16'd1});
    drive(0, 32'h0, 1);
    chk("idle_valid", {31'b0, ov_a}, 0);
    chk("cnt_s11", {cnt_a, cnt_m, 14'b0, cnt_c}, {16'd3, 16'd2, 16'd3});
    drive(1, 32'h0, 1);
    drive(1, 32'h0, 1);
    drive(0, 32'h0, 1);
    chk("cnt_sat_c", {30'b0, cnt_c}, 3);
    chk("cnt_5", {cnt_a, cnt_m}, {16'd5, 16'd4});

    // Stall: A held, B to skid, C refused until drain.
    drive(1, I_ADD, 0);
    chk("stall_a", {ov_a, rdy_a, fn_a}, {1'b1, 1'b1, F_ADD});
    drive(1, I_SUB, 0);
    chk("stall_hold", {ov_a, rdy_a, fn_a}, {1'b1, 1'b0, F_ADD});
    drive(1, I_ADDI, 0);
    chk("stall_full", {ov_a, rdy_a, fn_a}, {1'b1, 1'b0, F_ADD});
    drive(1, I_ADDI, 1);
    chk("drain_b", {ov_a, rdy_a, fn_a}, {1'b1, 1'b1, F_SUB});
    drive(1, I_ADDI, 1);
    chk("drain_c", {ov_a, fn_a, imm_a[7:0]}, {1'b1, F_ADD, 8'd5});
    drive(0, 32'h0, 1);
    chk("drain_done", {31'b0, ov_a}, 0);

    // Flush with both entries full and an input offered.
    drive(1, 32'h0, 0);
    drive(1, I_ADD, 0);
    chk("pre_flush_full", {ov_a, rdy_a, inv_a}, {1'b1, 1'b0, 1'b1});
    flush = 1'b1;
    drive(1, I_SUB, 0);
    flush = 1'b0;
    chk("flush", {ov_a, rdy_a, cnt_a}, {1'b0, 1'b1, 16'd5});
    drive(0, 32'h0, 1);
    chk("flush_dropped", {ov_a, cnt_a}, {1'b0, 16'd5});

    // Async reset in the middle of a stall.
    drive(1, I_ADD, 0);
    drive(1, I_SUB, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {ov_a, rdy_a, fn_a, cnt_a}, {1'b0, 1'b1, F_X, 16'd0});
    chk("async_rst_m", {ov_m, cnt_m}, {1'b0, 16'd0});
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
